if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues sequential fetch requests and buffers in-order responses.
// Redirects flush the queue and drop responses still in flight for the old path.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          QDEPTH   = 4,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_address_i,
    output logic              req_valid_o,
    output logic [31:0]       req_addr_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic [INST_W-1:0] resp_inst_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_pc_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              inst_ready_i,
    output logic              stall_from_if
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     outs;
    logic [CW-1:0]     disc;
    logic              en;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [31:0]       pc_q   [QDEPTH];
    logic [INST_W-1:0] inst_q [QDEPTH];

    logic [CW-1:0] reserved;
    logic          fire;
    logic          enq;
    logic          deq;

    // Slots already spoken for: queued entries plus live (non-discarded) requests.
    assign reserved = occ + outs - disc;

    assign req_valid_o   = en && !branch_flag_i && (reserved < CW'(QDEPTH));
    assign req_addr_o    = fetch_pc;
    assign fire          = req_valid_o && req_ready_i;
    assign enq           = resp_valid_i && (disc == '0) && !branch_flag_i;
    assign deq           = inst_valid_o && inst_ready_i && !branch_flag_i;

    assign inst_valid_o  = (occ != '0);
    assign inst_pc_o     = pc_q[rd_ptr];
    assign inst_o        = inst_q[rd_ptr];
    assign stall_from_if = !inst_valid_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            occ      <= '0;
            outs     <= '0;
            disc     <= '0;
            en       <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            en   <= 1'b1;
            outs <= outs + CW'(fire) - CW'(resp_valid_i);
            if (branch_flag_i) begin
                fetch_pc <= branch_address_i;
                resp_pc  <= branch_address_i;
                occ      <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Every response still owed after this edge belongs to the old path.
                disc     <= outs - CW'(resp_valid_i);
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_valid_i && (disc != '0))
                    disc <= disc - CW'(1);
                if (enq) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (deq)
                    rd_ptr <= rd_ptr + PW'(1);
                occ <= occ + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[wr_ptr]   <= resp_pc;
            inst_q[wr_ptr] <= resp_inst_i;
        end
    end

endmodule
